// File: rtl/taint_pkg.sv
// Shared helpers for the shadow-taint memory: alias matching and population count.
package taint_pkg;

  // Default address width; the top recomputes its own counter width from ABITS.
  localparam int unsigned DefAbits = 4;
  localparam int unsigned CNT_W = DefAbits + 1;

  // Widest vector popcount() accepts; callers zero-extend into it.
  localparam int unsigned PopMaxBits = 256;

  // Row r can be reached by address a whose tainted bits t are unknown.
  function automatic logic alias_match(input int unsigned r, input int unsigned a,
                                       input int unsigned t);
    return ((r ^ a) & ~t) == 32'd0;
  endfunction

  function automatic int unsigned popcount(input logic [PopMaxBits-1:0] vec);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < PopMaxBits; i++) begin
      cnt += 32'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/taint_popcount.sv
// Combinational count of set bits in an N-bit vector.
module taint_popcount
  import taint_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned CW = CNT_W
) (
  input  logic [N-1:0]  vec_i,
  output logic [CW-1:0] cnt_o
);

  logic [PopMaxBits-1:0] vec_ext;

  // Zero-extend into the fixed-width helper and narrow the result.
  always_comb begin
    vec_ext        = '0;
    vec_ext[N-1:0] = vec_i;
    cnt_o          = CW'(popcount(vec_ext));
  end

endmodule

// File: rtl/taintcell_mem_shadow.sv
// Shadow-taint RAM: one taint bit per data bit, multi-port, alias-conservative writes,
// synchronous clear and a registered count of tainted rows.
module taintcell_mem_shadow
  import taint_pkg::*;
#(
  parameter int unsigned         WIDTH          = 8,
  parameter int unsigned         SIZE           = 16,
  parameter int unsigned         ABITS          = 4,
  parameter int unsigned         RD_PORTS       = 2,
  parameter int unsigned         WR_PORTS       = 1,
  parameter logic [RD_PORTS-1:0] RD_TRANSPARENT = '0
) (
  input  logic                         pos_clk,
  input  logic                         pos_arst,
  input  logic                         clr,
  input  logic [RD_PORTS-1:0]          rd_en,
  input  logic [RD_PORTS-1:0]          rd_en_taint,
  input  logic [RD_PORTS*ABITS-1:0]    rd_addr,
  input  logic [RD_PORTS*ABITS-1:0]    rd_addr_taint,
  output logic [RD_PORTS*WIDTH-1:0]    rd_data_taint,
  input  logic [WR_PORTS*WIDTH-1:0]    wr_en,
  input  logic [WR_PORTS*WIDTH-1:0]    wr_en_taint,
  input  logic [WR_PORTS*ABITS-1:0]    wr_addr,
  input  logic [WR_PORTS*ABITS-1:0]    wr_addr_taint,
  input  logic [WR_PORTS*WIDTH-1:0]    wr_data_taint,
  output logic [ABITS:0]               taint_sum,
  output logic                         taint_any
);

  localparam int unsigned CntW = ABITS + 1;

  // Unpacked per-port views of the flat buses.
  logic [ABITS-1:0] wa   [WR_PORTS];
  logic [ABITS-1:0] wt   [WR_PORTS];
  logic [WIDTH-1:0] we   [WR_PORTS];
  logic [WIDTH-1:0] wet  [WR_PORTS];
  logic [WIDTH-1:0] wdt  [WR_PORTS];
  logic [ABITS-1:0] ra   [RD_PORTS];
  logic [ABITS-1:0] rt   [RD_PORTS];

  logic [WIDTH-1:0] mem_q  [SIZE];
  logic [WIDTH-1:0] mem_d  [SIZE];
  logic [WIDTH-1:0] wr_hit [SIZE];
  logic [WIDTH-1:0] wr_val [SIZE];
  logic [SIZE-1:0]  row_nz;

  logic [RD_PORTS*WIDTH-1:0] rd_q;
  logic [CntW-1:0]           sum_d, sum_q;
  logic                      any_q;

  // Split flat port buses into per-port arrays.
  always_comb begin
    for (int p = 0; p < WR_PORTS; p++) begin
      wa[p]  = wr_addr[p*ABITS +: ABITS];
      wt[p]  = wr_addr_taint[p*ABITS +: ABITS];
      we[p]  = wr_en[p*WIDTH +: WIDTH];
      wet[p] = wr_en_taint[p*WIDTH +: WIDTH];
      wdt[p] = wr_data_taint[p*WIDTH +: WIDTH];
    end
    for (int i = 0; i < RD_PORTS; i++) begin
      ra[i] = rd_addr[i*ABITS +: ABITS];
      rt[i] = rd_addr_taint[i*ABITS +: ABITS];
    end
  end

  // Post-write row contents: every port's effect on a bit is ORed, no port has priority.
  always_comb begin
    for (int unsigned r = 0; r < SIZE; r++) begin
      wr_hit[r] = '0;
      wr_val[r] = '0;
      for (int p = 0; p < WR_PORTS; p++) begin
        if (32'(wa[p]) == r) begin
          // Exact row: an enabled bit takes the combined taint, a tainted disable forces 1.
          wr_hit[r] = wr_hit[r] | we[p] | wet[p];
          wr_val[r] = wr_val[r] | (we[p] & (wdt[p] | {WIDTH{|wt[p]}} | wet[p]))
                                | (~we[p] & wet[p]);
        end else if ((wt[p] != '0) && alias_match(r, 32'(wa[p]), 32'(wt[p]))) begin
          // A row the tainted address might have meant: any possible write taints it.
          wr_hit[r] = wr_hit[r] | we[p] | wet[p];
          wr_val[r] = wr_val[r] | we[p] | wet[p];
        end
      end
      mem_d[r]  = (wr_val[r] & wr_hit[r]) | (mem_q[r] & ~wr_hit[r]);
      row_nz[r] = |mem_d[r];
    end
  end

  taint_popcount #(
    .N  (SIZE),
    .CW (CntW)
  ) u_popcount (
    .vec_i (row_nz),
    .cnt_o (sum_d)
  );

  // Row storage; clr wins over any same-edge write.
  always_ff @(posedge pos_clk or posedge pos_arst) begin
    if (pos_arst) begin
      for (int r = 0; r < SIZE; r++) mem_q[r] <= '0;
    end else if (clr) begin
      for (int r = 0; r < SIZE; r++) mem_q[r] <= '0;
    end else begin
      for (int r = 0; r < SIZE; r++) mem_q[r] <= mem_d[r];
    end
  end

  // Registered read ports; tainted enable or address poisons the whole word.
  always_ff @(posedge pos_clk or posedge pos_arst) begin
    if (pos_arst) begin
      rd_q <= '0;
    end else if (clr) begin
      rd_q <= '0;
    end else begin
      for (int i = 0; i < RD_PORTS; i++) begin
        if (rd_en_taint[i]) begin
          rd_q[i*WIDTH +: WIDTH] <= '1;
        end else if (rd_en[i]) begin
          if (rt[i] != '0) begin
            rd_q[i*WIDTH +: WIDTH] <= '1;
          end else if (32'(ra[i]) >= SIZE) begin
            rd_q[i*WIDTH +: WIDTH] <= '0;
          end else if (RD_TRANSPARENT[i]) begin
            rd_q[i*WIDTH +: WIDTH] <= mem_d[ra[i]];
          end else begin
            rd_q[i*WIDTH +: WIDTH] <= mem_q[ra[i]];
          end
        end
      end
    end
  end

  // Tainted-row count tracks the contents written at the same edge.
  always_ff @(posedge pos_clk or posedge pos_arst) begin
    if (pos_arst) begin
      sum_q <= '0;
      any_q <= 1'b0;
    end else if (clr) begin
      sum_q <= '0;
      any_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      any_q <= (sum_d != '0);
    end
  end

  assign rd_data_taint = rd_q;
  assign taint_sum     = sum_q;
  assign taint_any     = any_q;

endmodule

// File: tb/tb_taintcell_mem_shadow.sv
// Directed bench for the shadow-taint memory; a second instance with SIZE=12 covers
// out-of-range write addresses.
module tb_taintcell_mem_shadow;

  localparam int unsigned W  = 8;
  localparam int unsigned AB = 4;
  localparam int unsigned RP = 2;
  localparam int unsigned WP = 2;

  logic             pos_clk;
  logic             pos_arst;
  logic             clr;
  logic [RP-1:0]    rd_en, rd_en_taint;
  logic [RP*AB-1:0] rd_addr, rd_addr_taint;
  logic [WP*W-1:0]  wr_en, wr_en_taint, wr_data_taint;
  logic [WP*AB-1:0] wr_addr, wr_addr_taint;
  logic [RP*W-1:0]  rd_data_taint, rd_data_taint2;
  logic [AB:0]      taint_sum, taint_sum2;
  logic             taint_any, taint_any2;

  int n_cmp = 0;
  int n_bad = 0;

  taintcell_mem_shadow #(
    .WIDTH(W), .SIZE(16), .ABITS(AB), .RD_PORTS(RP), .WR_PORTS(WP), .RD_TRANSPARENT(2'b10)
  ) dut (
    .pos_clk(pos_clk), .pos_arst(pos_arst), .clr(clr),
    .rd_en(rd_en), .rd_en_taint(rd_en_taint), .rd_addr(rd_addr),
    .rd_addr_taint(rd_addr_taint), .rd_data_taint(rd_data_taint),
    .wr_en(wr_en), .wr_en_taint(wr_en_taint), .wr_addr(wr_addr),
    .wr_addr_taint(wr_addr_taint), .wr_data_taint(wr_data_taint),
    .taint_sum(taint_sum), .taint_any(taint_any)
  );

  taintcell_mem_shadow #(
    .WIDTH(W), .SIZE(12), .ABITS(AB), .RD_PORTS(RP), .WR_PORTS(WP), .RD_TRANSPARENT(2'b10)
  ) dut12 (
    .pos_clk(pos_clk), .pos_arst(pos_arst), .clr(clr),
    .rd_en(rd_en), .rd_en_taint(rd_en_taint), .rd_addr(rd_addr),
    .rd_addr_taint(rd_addr_taint), .rd_data_taint(rd_data_taint2),
    .wr_en(wr_en), .wr_en_taint(wr_en_taint), .wr_addr(wr_addr),
    .wr_addr_taint(wr_addr_taint), .wr_data_taint(wr_data_taint),
    .taint_sum(taint_sum2), .taint_any(taint_any2)
  );

  initial begin
    pos_clk = 1'b0;
    forever #5 pos_clk = ~pos_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    clr = 0; rd_en = '0; rd_en_taint = '0; rd_addr = '0; rd_addr_taint = '0;
    wr_en = '0; wr_en_taint = '0; wr_addr = '0; wr_addr_taint = '0; wr_data_taint = '0;
  endtask

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge pos_clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    pos_arst = 1'b1;
    #3;
    check("rst_rd", 32'(rd_data_taint), 32'h0);
    check("rst_sum", 32'(taint_sum), 32'h0);
    check("rst_any", 32'(taint_any), 32'h0);
    #8 pos_arst = 1'b0;  // released mid-cycle
    step();
    check("idle_sum", 32'(taint_sum), 32'h0);

    // Write row 3 on port0; port0 non-transparent, port1 transparent, both read row 3.
    wr_en[7:0] = 8'hFF; wr_addr[3:0] = 4'd3; wr_data_taint[7:0] = 8'h0F;
    rd_en = 2'b11; rd_addr = {4'd3, 4'd3};
    step();
    check("wr3_rd0_old", 32'(rd_data_taint[7:0]), 32'h00);
    check("wr3_rd1_trans", 32'(rd_data_taint[15:8]), 32'h0F);
    check("wr3_sum", 32'(taint_sum), 32'd1);
    check("wr3_any", 32'(taint_any), 32'd1);
    wr_en = '0; wr_data_taint = '0;
    step();
    check("wr3_rd0_next", 32'(rd_data_taint[7:0]), 32'h0F);

    // Tainted address 4 / taint 0011 aliases rows 4..7, bit 0 only.
    wr_en[7:0] = 8'h01; wr_addr[3:0] = 4'd4; wr_addr_taint[3:0] = 4'b0011;
    rd_addr = {4'd6, 4'd4};
    step();
    check("alias_rd0_old", 32'(rd_data_taint[7:0]), 32'h00);
    check("alias_rd1_row6", 32'(rd_data_taint[15:8]), 32'h01);
    check("alias_sum", 32'(taint_sum), 32'd5);
    idle_inputs();
    rd_en = 2'b11; rd_addr = {4'd7, 4'd5};
    step();
    check("alias_row5", 32'(rd_data_taint[7:0]), 32'h01);
    check("alias_row7", 32'(rd_data_taint[15:8]), 32'h01);

    // Both write ports on row 2 combine by OR.
    wr_en = 16'hFFFF; wr_addr = {4'd2, 4'd2}; wr_data_taint = {8'h80, 8'h01};
    rd_addr = {4'd2, 4'd2};
    step();
    check("dual_rd0_old", 32'(rd_data_taint[7:0]), 32'h00);
    check("dual_rd1_trans", 32'(rd_data_taint[15:8]), 32'h81);
    check("dual_sum", 32'(taint_sum), 32'd6);
    idle_inputs();
    rd_en = 2'b01; rd_addr = {4'd0, 4'd2};
    step();
    check("dual_row2", 32'(rd_data_taint[7:0]), 32'h81);

    // Read taint handling on port0; port1 disabled holds its value.
    rd_en = 2'b01; rd_addr = {4'd0, 4'd9}; rd_addr_taint = {4'd0, 4'b0001};
    step();
    check("rd_addr_taint", 32'(rd_data_taint[7:0]), 32'hFF);
    check("rd1_hold", 32'(rd_data_taint[15:8]), 32'h81);
    rd_addr = {4'd0, 4'd3}; rd_addr_taint = '0;
    step();
    check("rd_row3", 32'(rd_data_taint[7:0]), 32'h0F);
    rd_en = 2'b00; rd_en_taint = 2'b01;
    step();
    check("rd_en_taint", 32'(rd_data_taint[7:0]), 32'hFF);
    // Hold, while a tainted disable on port1 forces row 0 bit 0.
    rd_en_taint = '0;
    wr_en_taint[15:8] = 8'h01; wr_addr[7:4] = 4'd0;
    step();
    check("rd_hold", 32'(rd_data_taint[7:0]), 32'hFF);
    check("en_taint_sum", 32'(taint_sum), 32'd7);
    idle_inputs();
    rd_en = 2'b01; rd_addr = {4'd0, 4'd0};
    step();
    check("en_taint_row0", 32'(rd_data_taint[7:0]), 32'h01);

    // Fill every row, then clear while also writing row 1.
    idle_inputs();
    for (int a = 0; a < 16; a++) begin
      wr_en[7:0] = 8'hFF; wr_addr[3:0] = 4'(a); wr_data_taint[7:0] = 8'h11;
      step();
    end
    check("fill_sum", 32'(taint_sum), 32'd16);
    check("fill_sum12", 32'(taint_sum2), 32'd12);
    wr_addr[3:0] = 4'd1; clr = 1'b1; rd_en = 2'b11; rd_addr = {4'd1, 4'd1};
    step();
    check("clr_sum", 32'(taint_sum), 32'd0);
    check("clr_any", 32'(taint_any), 32'd0);
    check("clr_rd", 32'(rd_data_taint), 32'h0);
    idle_inputs();
    rd_en = 2'b11; rd_addr = {4'd1, 4'd1};
    step();
    check("clr_row1", 32'(rd_data_taint), 32'h0);

    // Out-of-range writes on the 12-row instance.
    idle_inputs();
    wr_en[7:0] = 8'h01; wr_addr[3:0] = 4'd5; wr_data_taint[7:0] = 8'h01;
    step();
    check("oor_pre16", 32'(taint_sum), 32'd1);
    check("oor_pre12", 32'(taint_sum2), 32'd1);
    wr_addr[3:0] = 4'hF;
    step();
    check("oor_exact16", 32'(taint_sum), 32'd2);
    check("oor_exact12", 32'(taint_sum2), 32'd1);
    wr_addr_taint[3:0] = 4'b1000;  // aliases rows 7 and 15
    step();
    check("oor_alias16", 32'(taint_sum), 32'd3);
    check("oor_alias12", 32'(taint_sum2), 32'd2);

    // Asynchronous reset mid-cycle, then normal operation on the next edge.
    idle_inputs();
    #2 pos_arst = 1'b1;
    #1;
    check("arst_sum", 32'(taint_sum), 32'd0);
    check("arst_any", 32'(taint_any), 32'd0);
    check("arst_rd", 32'(rd_data_taint), 32'h0);
    #1 pos_arst = 1'b0;
    wr_en[7:0] = 8'h01; wr_addr[3:0] = 4'd3; wr_data_taint[7:0] = 8'h01;
    step();
    check("post_arst_sum", 32'(taint_sum), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
